// File: rtl/ifu_inst_buffer.sv
// Instruction queue between fetch and decode: DEPTH-entry circular FIFO presenting its head to idu.
// Latency: a push into an empty buffer is visible at the head outputs the next cycle (no bypass).
// Backpressure: fetch_ready_o drops when full or flushing; stall_i holds the head in place.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   flush_i                   discard all entries (mispredict/trap); blocks same-cycle push and pop
//   stall_i                   decode stalled; head is not consumed
//   fetch_valid_i/ready_o     fetch response handshake
//   fetch_inst/addr/old_pc/taken_i   fetch response payload
//   inst_o, inst_addr_o, old_pc_o, branch_taken_o, inst_valid_o   head entry, or NOP/zeros when empty
//   count_o                   occupancy 0..DEPTH
module ifu_inst_buffer #(
    parameter int                 DEPTH    = 4,
    parameter int                 INST_W   = 32,
    parameter int                 ADDR_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h00000013)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       stall_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic [INST_W-1:0]          fetch_inst_i,
    input  logic [ADDR_W-1:0]          fetch_addr_i,
    input  logic [ADDR_W-1:0]          fetch_old_pc_i,
    input  logic                       fetch_taken_i,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          inst_addr_o,
    output logic [ADDR_W-1:0]          old_pc_o,
    output logic                       branch_taken_o,
    output logic                       inst_valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] old_pc;
        logic              taken;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    entry_t          head;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Ready ignores a same-cycle pop on purpose: keeps fetch_ready_o off the stall_i path.
    assign fetch_ready_o = !full && !flush_i;
    assign push          = fetch_valid_i && fetch_ready_o;
    assign pop           = !empty && !stall_i && !flush_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry contents need no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= '{inst:   fetch_inst_i,
                             addr:   fetch_addr_i,
                             old_pc: fetch_old_pc_i,
                             taken:  fetch_taken_i};
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        inst_o         = NOP_INST;
        inst_addr_o    = '0;
        old_pc_o       = '0;
        branch_taken_o = 1'b0;
        if (!empty) begin
            inst_o         = head.inst;
            inst_addr_o    = head.addr;
            old_pc_o       = head.old_pc;
            branch_taken_o = head.taken;
        end
    end

    assign inst_valid_o = !empty;
    assign count_o      = count;

endmodule

// File: tb/tb_ifu_inst_buffer.sv
module tb_ifu_inst_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        stall_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_inst_i;
    logic [31:0] fetch_addr_i;
    logic [31:0] fetch_old_pc_i;
    logic        fetch_taken_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [31:0] old_pc_o;
    logic        branch_taken_o;
    logic        inst_valid_o;
    logic [2:0]  count_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ifu_inst_buffer #(.DEPTH(DEPTH), .INST_W(32), .ADDR_W(32), .NOP_INST(NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .stall_i        (stall_i),
        .fetch_valid_i  (fetch_valid_i),
        .fetch_ready_o  (fetch_ready_o),
        .fetch_inst_i   (fetch_inst_i),
        .fetch_addr_i   (fetch_addr_i),
        .fetch_old_pc_i (fetch_old_pc_i),
        .fetch_taken_i  (fetch_taken_i),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o),
        .old_pc_o       (old_pc_o),
        .branch_taken_o (branch_taken_o),
        .inst_valid_o   (inst_valid_o),
        .count_o        (count_o)
    );

    // Reference model: an ordered list of buffered instructions.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] old_pc;
        logic        taken;
    } ent_t;

    ent_t q[$];

    function automatic logic [31:0] m_inst();
        return (q.size() > 0) ? q[0].inst : NOP;
    endfunction
    function automatic logic [31:0] m_addr();
        return (q.size() > 0) ? q[0].addr : 32'h0;
    endfunction
    function automatic logic [31:0] m_old_pc();
        return (q.size() > 0) ? q[0].old_pc : 32'h0;
    endfunction
    function automatic logic m_taken();
        return (q.size() > 0) ? q[0].taken : 1'b0;
    endfunction

    // Drive one cycle from a negedge, sample ready, advance the model at the posedge,
    // and return at the next negedge with outputs settled.
    task automatic step(input bit r, input bit f, input bit s, input bit v,
                        input logic [31:0] inst, input logic [31:0] addr,
                        input logic [31:0] opc, input bit tk, output bit rdy_seen);
        bit   do_push;
        bit   do_pop;
        ent_t e;
        rst            = r;
        flush_i        = f;
        stall_i        = s;
        fetch_valid_i  = v;
        fetch_inst_i   = inst;
        fetch_addr_i   = addr;
        fetch_old_pc_i = opc;
        fetch_taken_i  = tk;
        #1;
        rdy_seen = fetch_ready_o;
        do_push  = !r && !f && v && (q.size() < DEPTH);
        do_pop   = !r && !f && !s && (q.size() > 0);
        e.inst = inst; e.addr = addr; e.old_pc = opc; e.taken = tk;
        @(posedge clk);
        if (r || f) begin
            q.delete();
        end else begin
            if (do_pop)  q.delete(0);
            if (do_push) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit rdy;
        step(1, 0, 0, 0, 0, 0, 0, 0, rdy);
        step(1, 0, 0, 0, 0, 0, 0, 0, rdy);
        step(0, 0, 0, 0, 0, 0, 0, 0, rdy);
        checks++; if (inst_o !== NOP) begin failures++; $display("FAIL reset_inst got=%h exp=%h", inst_o, NOP); end
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid_o); end
        checks++; if (fetch_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", fetch_ready_o); end
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (inst_addr_o !== 32'h0 || old_pc_o !== 32'h0 || branch_taken_o !== 1'b0) begin
            failures++; $display("FAIL reset_zero addr=%h old_pc=%h taken=%b exp=0/0/0", inst_addr_o, old_pc_o, branch_taken_o);
        end
    endtask

    task automatic test_single();
        bit rdy;
        step(0, 0, 0, 1, 32'h00500093, 32'h80000000, 32'h7ffffffc, 0, rdy);
        checks++; if (inst_o !== 32'h00500093) begin failures++; $display("FAIL single_inst got=%h exp=00500093", inst_o); end
        checks++; if (inst_addr_o !== 32'h80000000) begin failures++; $display("FAIL single_addr got=%h exp=80000000", inst_addr_o); end
        checks++; if (old_pc_o !== 32'h7ffffffc) begin failures++; $display("FAIL single_old_pc got=%h exp=7ffffffc", old_pc_o); end
        checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", inst_valid_o); end
        step(0, 0, 0, 0, 0, 0, 0, 0, rdy);
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin
            failures++; $display("FAIL single_drain valid=%b inst=%h exp=0/%h", inst_valid_o, inst_o, NOP);
        end
    endtask

    task automatic test_stall_fill();
        bit rdy;
        logic [31:0] ins [5];
        for (int i = 0; i < 5; i++) ins[i] = 32'h0A000013 + 32'h01000000 * i;
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, ins[i], 32'h200 + 4*i, 32'h1F0, i[0], rdy);
        checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count_o); end
        checks++; if (fetch_ready_o !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", fetch_ready_o); end
        checks++; if (inst_o !== ins[0]) begin failures++; $display("FAIL fill_head got=%h exp=%h", inst_o, ins[0]); end
        step(0, 0, 1, 1, ins[4], 32'h210, 32'h1F0, 0, rdy);
        checks++; if (rdy !== 1'b0 || count_o !== 3'd4) begin
            failures++; $display("FAIL fill_fifth ready=%b count=%0d exp=0/4", rdy, count_o);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (inst_o !== ins[i] || inst_addr_o !== 32'h200 + 4*i || branch_taken_o !== i[0]) begin
                failures++; $display("FAIL drain_order[%0d] inst=%h addr=%h tk=%b exp=%h/%h/%b",
                                     i, inst_o, inst_addr_o, branch_taken_o, ins[i], 32'h200 + 4*i, i[0]);
            end
            step(0, 0, 0, 0, 0, 0, 0, 0, rdy);
        end
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin
            failures++; $display("FAIL drain_empty valid=%b inst=%h", inst_valid_o, inst_o);
        end
    endtask

    task automatic test_back_to_back();
        bit rdy;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1, 32'h00000093 + i, 32'h100 + 4*i, 32'h0, 0, rdy);
            checks++;
            if (inst_addr_o !== 32'h100 + 4*i || inst_o !== 32'h00000093 + i || count_o !== 3'd1) begin
                failures++; $display("FAIL b2b[%0d] addr=%h inst=%h count=%0d exp=%h/%h/1",
                                     i, inst_addr_o, inst_o, count_o, 32'h100 + 4*i, 32'h00000093 + i);
            end
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic test_flush();
        bit rdy;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 32'h11100013 + i, 32'h300 + 4*i, 0, 0, rdy);
        step(0, 1, 0, 1, 32'hDEAD0013, 32'h3F0, 0, 1, rdy);
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", rdy); end
        checks++; if (count_o !== 3'd0 || inst_valid_o !== 1'b0 || inst_o !== NOP) begin
            failures++; $display("FAIL flush_clear count=%0d valid=%b inst=%h exp=0/0/%h", count_o, inst_valid_o, inst_o, NOP);
        end
        step(0, 0, 0, 1, 32'h00100073, 32'h400, 0, 0, rdy);
        checks++; if (inst_o !== 32'h00100073 || count_o !== 3'd1) begin
            failures++; $display("FAIL flush_after inst=%h count=%0d exp=00100073/1", inst_o, count_o);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, rdy);
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL flush_alone valid=%b exp=0", inst_valid_o); end
    endtask

    task automatic test_reset_mid();
        bit rdy;
        for (int i = 0; i < 2; i++) step(0, 0, 1, 1, 32'h22200013 + i, 32'h500 + 4*i, 32'h4FC, 1, rdy);
        step(1, 0, 1, 1, 32'h33300013, 32'h600, 0, 1, rdy);
        rst = 1'b0; fetch_valid_i = 1'b0; #1;
        checks++;
        if (inst_o !== NOP || inst_addr_o !== 0 || old_pc_o !== 0 || branch_taken_o !== 0 ||
            inst_valid_o !== 0 || count_o !== 0 || fetch_ready_o !== 1'b1) begin
            failures++; $display("FAIL reset_mid inst=%h addr=%h opc=%h tk=%b v=%b cnt=%0d rdy=%b",
                                 inst_o, inst_addr_o, old_pc_o, branch_taken_o, inst_valid_o, count_o, fetch_ready_o);
        end
    endtask

    task automatic test_random();
        bit rdy;
        bit r, f, s, v, exp_rdy;
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 59) == 0);
            f = ($urandom_range(0, 14) == 0);
            s = ($urandom_range(0, 2) == 0);
            v = ($urandom_range(0, 2) != 0);
            exp_rdy = (q.size() < DEPTH) && !f;
            step(r, f, s, v, $urandom, $urandom, $urandom, 1'($urandom), rdy);
            checks++;
            if (rdy !== exp_rdy) begin
                failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", n, rdy, exp_rdy);
            end
            checks++;
            if (inst_o !== m_inst() || inst_addr_o !== m_addr() || old_pc_o !== m_old_pc() ||
                branch_taken_o !== m_taken() || inst_valid_o !== (q.size() > 0) ||
                count_o !== 3'(q.size())) begin
                failures++; $display("FAIL rand_head[%0d] inst=%h/%h addr=%h/%h opc=%h/%h tk=%b/%b v=%b cnt=%0d/%0d",
                                     n, inst_o, m_inst(), inst_addr_o, m_addr(), old_pc_o, m_old_pc(),
                                     branch_taken_o, m_taken(), inst_valid_o, count_o, q.size());
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0; fetch_valid_i = 1'b0;
        fetch_inst_i = '0; fetch_addr_i = '0; fetch_old_pc_i = '0; fetch_taken_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_stall_fill();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
